multi_debounce: RTL and testbench
=================================

Name: multi_debounce

Overview:
- Parametrised multi-channel debouncer and next generation of the single-channel LED debounce block.
- Each channel has a 2-flop synchroniser, a saturating up/down integrator and hysteretic on/off thresholds.
- A shared sample-rate prescaler sets the integration rate.
- Outputs per channel: a clean level and single-cycle rise/fall strobes. The block sits between raw button/switch pins and control logic.

Parameters:
- CH_NUM, 4, number of independent input channels (>=1)
- CNT_BW, 4, integrator width per channel
- CNT_MAX, 11, integrator saturation value (<= 2**CNT_BW-1)
- ON_THR, 9, integrator value at or above which a low output goes high
- OFF_THR, 2, integrator value at or below which a high output goes low (OFF_THR < ON_THR <= CNT_MAX)
- PRESCALE, 1, clk cycles per integration tick (>=1; 1 = every cycle)
- PRE_BW, 16, prescaler counter width (2**PRE_BW >= PRESCALE)

Ports:
- clk  in  1  system clock, all logic on rising edge
- aclr  in  1  asynchronous reset, active-high; clears all state
- reset  in  1  synchronous clear, active-high; same effect as aclr at the next clk edge
- data  in  CH_NUM  raw asynchronous inputs, bit n = channel n
- level  out  CH_NUM  debounced level per channel
- rise  out  CH_NUM  one-cycle strobe when level[n] goes 0->1
- fall  out  CH_NUM  one-cycle strobe when level[n] goes 1->0

Behaviour:
- Reset (aclr async, or reset sync):
  - sync flops, integrators, level, rise, fall = 0
  - prescaler count = 0
  - aclr wins over reset; reset wins over all other activity
- Synchroniser per channel: s0 <= data[n]; s1 <= s0. Only s1 feeds the integrator.
- Prescaler:
  - pcnt counts 0..PRESCALE-1 and wraps to 0.
  - tick = (pcnt == PRESCALE-1), combinational from the registered pcnt.
  - When PRESCALE=1, tick is constantly 1.
- Integrator per channel, updated only on tick:
  - s1=1 and cnt<CNT_MAX: cnt+1
  - s1=0 and cnt>0: cnt-1
  - otherwise hold. Saturates at both ends; never wraps.
- Level state machine per channel, 2 states, evaluated every clk from the registered cnt:
  - LOW -> HIGH when cnt >= ON_THR
  - HIGH -> LOW when cnt <= OFF_THR
  - otherwise hold. The band OFF_THR < cnt < ON_THR holds the current state (hysteresis).
- Strobes:
  - rise[n]/fall[n] are registered and asserted for exactly the one cycle in which the new level[n] first appears.
  - Never both at once on one channel.
- Latency (PRESCALE=1, from reset state): a data step sampled at edge 1 gives level=1 after edge ON_THR+3 (default: edge 12).
- With PRESCALE=P, integration steps occur only on ticks, so latency is about ON_THR*P + 3 cycles, depending on tick phase.
- Channels are fully independent; simultaneous transitions on several channels each produce their own strobes.
- Reset mid-debounce discards the partial count. After release, the channel restarts from cnt=0, level=0, with no strobe on release.
- The async path of aclr must not depend on clk. Release is assumed synchronised upstream.

Test Plan:
- Step on ch0 (PRESCALE=1): after reset, data=4'b0001 held -> cnt0 reaches 9 after edge 11, level[0]=1 and rise[0]=1 for one cycle after edge 12; cnt0 saturates at 11; other channels stay 0.
- Glitch rejection: single-cycle pulse data[1]=1 -> cnt1 peaks at 1 and returns to 0, level[1], rise[1], fall[1] stay 0.
- Hysteresis: ch0 high and saturated (cnt=11), then data[0]=0:
  - after 6 ticks, cnt=5 and level stays 1
  - cnt=2 after the 9th tick, then level=0 with fall[0] pulse one cycle later
  - data back to 1 at cnt=5 -> no change in level
- Chatter: data[2] toggling every cycle for 200 cycles -> cnt2 oscillates between 0 and 1, no strobes; 50% duty with period 4 keeps level at its prior value.
- Prescaler: PRESCALE=4, step on ch3 -> cnt3 increments only on every 4th cycle, level[3] rises 36-39 cycles after the sampled step, rise[3] width is 1 cycle.
- Reset mid-operation:
  - aclr pulse (not clock-aligned) while cnt0=7 -> level, cnt and strobes are 0 immediately.
  - Same with sync reset -> cleared at the next edge.
  - data held at 1 after release -> full ON_THR+3 latency again, with a single rise strobe.

Source files
------------

// File: rtl/multi_debounce.sv
// Multi-channel debouncer: per-channel 2-flop synchroniser, saturating up/down
// integrator and hysteretic level FSM, all stepped by a shared sample prescaler.
module multi_debounce #(
   parameter int CH_NUM   = 4,
   parameter int CNT_BW   = 4,
   parameter int CNT_MAX  = 11,
   parameter int ON_THR   = 9,
   parameter int OFF_THR  = 2,
   parameter int PRESCALE = 1,
   parameter int PRE_BW   = 16
) (
   input  logic              clk,
   input  logic              aclr,
   input  logic              reset,
   input  logic [CH_NUM-1:0] data,
   output logic [CH_NUM-1:0] level,
   output logic [CH_NUM-1:0] rise,
   output logic [CH_NUM-1:0] fall
);

   typedef enum logic {
      ST_LOW  = 1'b0,
      ST_HIGH = 1'b1
   } state_t;

   localparam logic [PRE_BW-1:0] PRE_ZERO = {PRE_BW{1'b0}};
   localparam logic [PRE_BW-1:0] PRE_ONE  = PRE_BW'(1);
   localparam logic [PRE_BW-1:0] PRE_LAST = PRE_BW'(PRESCALE - 1);
   localparam logic [CNT_BW-1:0] CNT_ZERO = {CNT_BW{1'b0}};
   localparam logic [CNT_BW-1:0] CNT_ONE  = CNT_BW'(1);
   localparam logic [CNT_BW-1:0] CNT_TOP  = CNT_BW'(CNT_MAX);
   localparam logic [CNT_BW-1:0] ON_LVL   = CNT_BW'(ON_THR);
   localparam logic [CNT_BW-1:0] OFF_LVL  = CNT_BW'(OFF_THR);
   localparam logic [CH_NUM-1:0] CH_ZERO  = {CH_NUM{1'b0}};

   logic [CH_NUM-1:0] sync0_r;
   logic [CH_NUM-1:0] sync1_r;
   logic [PRE_BW-1:0] pcnt_r;
   logic              tick_s;
   logic [CNT_BW-1:0] cnt_r       [CH_NUM];
   logic [CNT_BW-1:0] cnt_nxt_s   [CH_NUM];
   state_t            state_r     [CH_NUM];
   state_t            state_nxt_s [CH_NUM];

   // With PRESCALE=1 the counter never leaves zero, so tick stays high.
   assign tick_s = (pcnt_r == PRE_LAST);

   // Input synchroniser; only sync1_r is allowed to reach the integrators.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         sync0_r <= CH_ZERO;
         sync1_r <= CH_ZERO;
      end else if (reset) begin
         sync0_r <= CH_ZERO;
         sync1_r <= CH_ZERO;
      end else begin
         sync0_r <= data;
         sync1_r <= sync0_r;
      end
   end

   // Shared sample-rate prescaler.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         pcnt_r <= PRE_ZERO;
      end else if (reset) begin
         pcnt_r <= PRE_ZERO;
      end else if (tick_s) begin
         pcnt_r <= PRE_ZERO;
      end else begin
         pcnt_r <= pcnt_r + PRE_ONE;
      end
   end

   // Integrator next value: saturating step toward the synchronised input.
   always_comb begin
      for (int n = 0; n < CH_NUM; n++) begin
         cnt_nxt_s[n] = cnt_r[n];
         if (tick_s && sync1_r[n] && (cnt_r[n] < CNT_TOP)) begin
            cnt_nxt_s[n] = cnt_r[n] + CNT_ONE;
         end else if (tick_s && !sync1_r[n] && (cnt_r[n] > CNT_ZERO)) begin
            cnt_nxt_s[n] = cnt_r[n] - CNT_ONE;
         end else begin
            cnt_nxt_s[n] = cnt_r[n];
         end
      end
   end

   // Level FSM next state; the band between thresholds holds the state.
   always_comb begin
      for (int n = 0; n < CH_NUM; n++) begin
         state_nxt_s[n] = state_r[n];
         case (state_r[n])
            ST_LOW: begin
               if (cnt_r[n] >= ON_LVL) begin
                  state_nxt_s[n] = ST_HIGH;
               end else begin
                  state_nxt_s[n] = ST_LOW;
               end
            end
            ST_HIGH: begin
               if (cnt_r[n] <= OFF_LVL) begin
                  state_nxt_s[n] = ST_LOW;
               end else begin
                  state_nxt_s[n] = ST_HIGH;
               end
            end
            default: state_nxt_s[n] = ST_LOW;
         endcase
      end
   end

   // Integrator, level state and edge strobes; strobes mark the first cycle of a new level.
   always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
         for (int n = 0; n < CH_NUM; n++) begin
            cnt_r[n]   <= CNT_ZERO;
            state_r[n] <= ST_LOW;
         end
         rise <= CH_ZERO;
         fall <= CH_ZERO;
      end else if (reset) begin
         for (int n = 0; n < CH_NUM; n++) begin
            cnt_r[n]   <= CNT_ZERO;
            state_r[n] <= ST_LOW;
         end
         rise <= CH_ZERO;
         fall <= CH_ZERO;
      end else begin
         for (int n = 0; n < CH_NUM; n++) begin
            cnt_r[n]   <= cnt_nxt_s[n];
            state_r[n] <= state_nxt_s[n];
            rise[n]    <= (state_r[n] == ST_LOW)  && (state_nxt_s[n] == ST_HIGH);
            fall[n]    <= (state_r[n] == ST_HIGH) && (state_nxt_s[n] == ST_LOW);
         end
      end
   end

   // The level output is a direct view of the state flops.
   always_comb begin
      level = CH_ZERO;
      for (int n = 0; n < CH_NUM; n++) begin
         level[n] = (state_r[n] == ST_HIGH);
      end
   end

endmodule

// File: tb/tb_multi_debounce.sv
// Directed bench for multi_debounce: default instance plus a PRESCALE=4 instance,
// expected outputs queued per edge and compared after that edge.
module tb_multi_debounce;

   logic       clk = 1'b0;
   logic       aclr;
   logic       reset;
   logic [3:0] data;
   logic [3:0] data_p4;
   logic [3:0] level, rise, fall;
   logic [3:0] level_p4, rise_p4, fall_p4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      logic [3:0] lvl;
      logic [3:0] rs;
      logic [3:0] fl;
   } exp_t;

   exp_t exp_q[$];

   multi_debounce dut (
      .clk(clk), .aclr(aclr), .reset(reset), .data(data),
      .level(level), .rise(rise), .fall(fall)
   );

   multi_debounce #(.PRESCALE(4)) dut_p4 (
      .clk(clk), .aclr(aclr), .reset(reset), .data(data_p4),
      .level(level_p4), .rise(rise_p4), .fall(fall_p4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push_exp(input string tag, input logic [3:0] lvl, input logic [3:0] rs,
                           input logic [3:0] fl);
      exp_t e;
      e.tag = tag;
      e.lvl = lvl;
      e.rs  = rs;
      e.fl  = fl;
      exp_q.push_back(e);
   endtask

   // One clock edge, then compare every queued expectation against the outputs.
   task automatic tick_check();
      exp_t e;
      @(posedge clk);
      #1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({e.tag, "_level"}, {28'd0, level}, {28'd0, e.lvl});
         chk({e.tag, "_rise"},  {28'd0, rise},  {28'd0, e.rs});
         chk({e.tag, "_fall"},  {28'd0, fall},  {28'd0, e.fl});
      end
   endtask

   // Edges e0..e1 counted from the edge that first samples the current data.
   // Level is 'base' before edge 'at', then base with fmask cleared and rmask set.
   task automatic run_seq(input string tag, input int e0, input int e1, input logic [3:0] base,
                          input logic [3:0] rmask, input logic [3:0] fmask, input int at);
      logic [3:0] lvl;
      for (int e = e0; e <= e1; e++) begin
         lvl = (e >= at) ? ((base & ~fmask) | rmask) : base;
         push_exp(tag, lvl, (e == at) ? rmask : 4'b0000, (e == at) ? fmask : 4'b0000);
         tick_check();
      end
   endtask

   initial begin
      int         rise_edge;
      int         nrise;
      int         nchg;
      int         last_chg;
      logic [3:0] prev_cnt;

      aclr    = 1'b1;
      reset   = 1'b0;
      data    = 4'b0000;
      data_p4 = 4'b0000;
      #22;
      aclr = 1'b0;
      chk("reset_level", {28'd0, level}, 32'd0);
      chk("reset_rise",  {28'd0, rise},  32'd0);
      chk("reset_fall",  {28'd0, fall},  32'd0);
      chk("reset_cnt0",  {28'd0, dut.cnt_r[0]}, 32'd0);
      tick_check();

      // Step on ch0: level after edge 12, saturation at 11.
      data = 4'b0001;
      run_seq("step0", 1, 11, 4'b0000, 4'b0001, 4'b0000, 12);
      chk("step0_cnt_e11", {28'd0, dut.cnt_r[0]}, 32'd9);
      run_seq("step0", 12, 16, 4'b0000, 4'b0001, 4'b0000, 12);
      chk("step0_cnt_sat", {28'd0, dut.cnt_r[0]}, 32'd11);

      // Single-cycle glitch on ch1.
      data = 4'b0011;
      run_seq("glitch", 1, 1, 4'b0001, 4'b0000, 4'b0000, 99);
      data = 4'b0001;
      run_seq("glitch", 2, 3, 4'b0001, 4'b0000, 4'b0000, 99);
      chk("glitch_cnt_peak", {28'd0, dut.cnt_r[1]}, 32'd1);
      run_seq("glitch", 4, 6, 4'b0001, 4'b0000, 4'b0000, 99);
      chk("glitch_cnt_end", {28'd0, dut.cnt_r[1]}, 32'd0);

      // Hysteresis: partial decay then recovery, then full decay.
      data = 4'b0000;
      run_seq("hyst_a", 1, 8, 4'b0001, 4'b0000, 4'b0000, 99);
      chk("hyst_cnt5", {28'd0, dut.cnt_r[0]}, 32'd5);
      data = 4'b0001;
      run_seq("hyst_b", 1, 14, 4'b0001, 4'b0000, 4'b0000, 99);
      chk("hyst_cnt_back", {28'd0, dut.cnt_r[0]}, 32'd11);
      data = 4'b0000;
      run_seq("hyst_c", 1, 11, 4'b0001, 4'b0000, 4'b0001, 12);
      chk("hyst_cnt2", {28'd0, dut.cnt_r[0]}, 32'd2);
      run_seq("hyst_c", 12, 14, 4'b0001, 4'b0000, 4'b0001, 12);

      // Chatter on ch2 while ch0 steps up independently.
      data = 4'b0101;
      for (int i = 1; i <= 200; i++) begin
         run_seq("chatter", i, i, 4'b0000, 4'b0001, 4'b0000, 12);
         chk("chatter_cnt2_le1", {31'd0, (dut.cnt_r[2] <= 4'd1)}, 32'd1);
         data[2] = ~data[2];
      end
      for (int i = 0; i < 40; i++) begin
         data = ((i % 4) < 2) ? 4'b0101 : 4'b0000;
         run_seq("period4", i + 1, i + 1, 4'b0001, 4'b0000, 4'b0000, 99);
      end

      // Sync reset with ch0 high: cleared at the edge, no fall strobe.
      reset = 1'b1;
      data  = 4'b0000;
      push_exp("srst_hi", 4'b0000, 4'b0000, 4'b0000);
      tick_check();
      reset = 1'b0;
      chk("srst_hi_cnt0", {28'd0, dut.cnt_r[0]}, 32'd0);

      // Simultaneous rises, then ch0 falls alone.
      data = 4'b0101;
      run_seq("simul", 1, 14, 4'b0000, 4'b0101, 4'b0000, 12);
      data = 4'b0100;
      run_seq("fall0", 1, 13, 4'b0101, 4'b0000, 4'b0001, 12);

      // Async clear mid-debounce, not aligned to the clock.
      data = 4'b0101;
      run_seq("pre_aclr", 1, 9, 4'b0100, 4'b0000, 4'b0000, 99);
      chk("pre_aclr_cnt0", {28'd0, dut.cnt_r[0]}, 32'd7);
      #2;
      aclr = 1'b1;
      #1;
      chk("aclr_level", {28'd0, level}, 32'd0);
      chk("aclr_rise",  {28'd0, rise},  32'd0);
      chk("aclr_fall",  {28'd0, fall},  32'd0);
      chk("aclr_cnt0",  {28'd0, dut.cnt_r[0]}, 32'd0);
      chk("aclr_cnt2",  {28'd0, dut.cnt_r[2]}, 32'd0);
      #3;
      aclr = 1'b0;
      run_seq("aclr_rel", 1, 14, 4'b0000, 4'b0101, 4'b0000, 12);

      // Sync reset mid-debounce.
      data = 4'b0000;
      run_seq("fall_both", 1, 13, 4'b0101, 4'b0000, 4'b0101, 12);
      data = 4'b0001;
      run_seq("pre_srst", 1, 9, 4'b0000, 4'b0000, 4'b0000, 99);
      chk("pre_srst_cnt0", {28'd0, dut.cnt_r[0]}, 32'd7);
      reset = 1'b1;
      #1;
      chk("srst_not_async", {28'd0, dut.cnt_r[0]}, 32'd7);
      push_exp("srst_mid", 4'b0000, 4'b0000, 4'b0000);
      tick_check();
      reset = 1'b0;
      chk("srst_mid_cnt0", {28'd0, dut.cnt_r[0]}, 32'd0);
      run_seq("srst_rel", 1, 14, 4'b0000, 4'b0001, 4'b0000, 12);

      // Prescaled instance: step on ch3.
      data_p4   = 4'b1000;
      rise_edge = 0;
      nrise     = 0;
      nchg      = 0;
      last_chg  = 0;
      prev_cnt  = dut_p4.cnt_r[3];
      for (int e = 1; e <= 52; e++) begin
         tick_check();
         if (dut_p4.cnt_r[3] != prev_cnt) begin
            if (last_chg != 0) begin
               chk("p4_tick_spacing", e - last_chg, 32'd4);
            end
            last_chg = e;
            nchg++;
            prev_cnt = dut_p4.cnt_r[3];
         end
         if (rise_p4[3]) begin
            nrise++;
            if (rise_edge == 0) begin
               rise_edge = e;
            end
         end
      end
      chk("p4_rise_window", {31'd0, (rise_edge >= 36 && rise_edge <= 39)}, 32'd1);
      chk("p4_rise_count", nrise, 32'd1);
      chk("p4_steps", nchg, 32'd11);
      chk("p4_level", {28'd0, level_p4}, 32'h8);
      chk("p4_fall", {28'd0, fall_p4}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
